// File: rtl/reg_file_8x8_pkg.sv
// Shared register-file constants and the write-back request type.
// The ALU and control unit reuse the same widths and reset value.
package reg_file_8x8_pkg;
  localparam int NREGS      = 8;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int NUM_RD     = 2;
  localparam logic [REG_DATA_W-1:0] REG_RESET_VAL = 8'h00;
  // Behavioural model delays; the synthesizable RTL itself has zero delay.
  localparam int REG_RD_DLY = 2;
  localparam int REG_WR_DLY = 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/reg_wb_buffer.sv
// One-entry write-back buffer. It holds a write that arrived during a stall,
// drives its commit, and bypasses its data onto every read port.
module reg_wb_buffer
  import reg_file_8x8_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic                                   wr_i,
  input  logic                                   busy_i,
  input  wb_req_t                                req_i,
  input  logic [NUM_RD-1:0][REG_ADDR_W-1:0]      rd_addr_i,
  output logic                                   pending_o,
  output logic                                   commit_o,
  output wb_req_t                                commit_req_o,
  output logic [NUM_RD-1:0]                      hit_o,
  output logic [NUM_RD-1:0][REG_DATA_W-1:0]      hit_data_o
);
  logic    valid_q, valid_d;
  wb_req_t ent_q, ent_d;

  // A stalled write always wins the buffer; once the stall drops the entry drains.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    if (wr_i && busy_i) begin
      valid_d = 1'b1;
      ent_d   = req_i;
    end else if (!busy_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end

  // Drop the buffered value when a direct write to the same register lands on the commit edge.
  assign commit_o     = valid_q && !busy_i && !(wr_i && (req_i.addr == ent_q.addr));
  assign commit_req_o = ent_q;
  assign pending_o    = valid_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_byp
    assign hit_o[p]      = valid_q && (rd_addr_i[p] == ent_q.addr);
    assign hit_data_o[p] = ent_q.data;
  end
endmodule

// File: rtl/reg_file_8x8.sv
// 8x8 register file: two combinational read ports, one write port with a
// stall-tolerant pending-write buffer bypassed onto the reads.
module reg_file_8x8
  import reg_file_8x8_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_DATA_W-1:0] IN,
  input  logic [REG_ADDR_W-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic                  BUSYWAIT,
  input  logic [REG_ADDR_W-1:0] OUT1ADDRESS,
  input  logic [REG_ADDR_W-1:0] OUT2ADDRESS,
  output logic [REG_DATA_W-1:0] OUT1,
  output logic [REG_DATA_W-1:0] OUT2,
  output logic                  PENDING
);
  logic [NREGS-1:0][REG_DATA_W-1:0]  regs_q, regs_d;
  logic [NUM_RD-1:0][REG_ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][REG_DATA_W-1:0] rd_data, hit_data;
  logic [NUM_RD-1:0]                 hit;
  logic                              commit;
  wb_req_t                           commit_req, req;

  assign req     = '{addr: INADDRESS, data: IN};
  assign rd_addr = {OUT2ADDRESS, OUT1ADDRESS};

  reg_wb_buffer u_wb (
    .clk_i        (CLK),
    .rst_n_i      (RESET),
    .wr_i         (WRITE),
    .busy_i       (BUSYWAIT),
    .req_i        (req),
    .rd_addr_i    (rd_addr),
    .pending_o    (PENDING),
    .commit_o     (commit),
    .commit_req_o (commit_req),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  // Commit first, then the direct write, so a same-address direct write wins.
  always_comb begin
    regs_d = regs_q;
    if (commit)
      regs_d[commit_req.addr] = commit_req.data;
    if (WRITE && !BUSYWAIT)
      regs_d[INADDRESS] = IN;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) regs_q <= {NREGS{REG_RESET_VAL}};
    else        regs_q <= regs_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_data[p] = hit[p] ? hit_data[p] : regs_q[rd_addr[p]];
  end

  assign OUT1 = rd_data[0];
  assign OUT2 = rd_data[1];
endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed vector table, a multiply write-back sequence, then random traffic
// checked against an array-based reference model of the register file.
module tb_reg_file_8x8;
  logic       CLK = 1'b0;
  logic       RESET, WRITE, BUSYWAIT, PENDING;
  logic [7:0] IN, OUT1, OUT2;
  logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS;

  int n_vec = 0;
  int n_err = 0;

  reg_file_8x8 dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .BUSYWAIT(BUSYWAIT), .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1), .OUT2(OUT2), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n, wr, busy;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] a1, a2;
    logic [7:0] e1, e2;
    logic       ep;
  } vec_t;

  vec_t tbl[20];

  // Reference model state
  logic [7:0] m_reg[8];
  logic       m_pv;
  logic [2:0] m_pa;
  logic [7:0] m_pd;

  task automatic drive(input logic r, w, b, input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] a1, a2);
    @(negedge CLK);
    RESET = r; WRITE = w; BUSYWAIT = b; INADDRESS = wa; IN = wd;
    OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] e1, e2, input logic ep);
    n_vec++;
    if (OUT1 !== e1 || OUT2 !== e2 || PENDING !== ep) begin
      n_err++;
      $display("FAIL %s: got OUT1=%h OUT2=%h PENDING=%b, want OUT1=%h OUT2=%h PENDING=%b",
               name, OUT1, OUT2, PENDING, e1, e2, ep);
    end
  endtask

  // Architectural rules: reset clears; a released stall drains the buffer,
  // then any direct write lands (so it wins on the same address).
  task automatic model_edge(input logic r, w, b, input logic [2:0] wa, input logic [7:0] wd);
    if (!r) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      m_pv = 1'b0;
    end else if (b) begin
      if (w) begin m_pv = 1'b1; m_pa = wa; m_pd = wd; end
    end else begin
      if (m_pv) m_reg[m_pa] = m_pd;
      m_pv = 1'b0;
      if (w) m_reg[wa] = wd;
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [2:0] a);
    return (m_pv && a == m_pa) ? m_pd : m_reg[a];
  endfunction

  initial begin
    logic [7:0] prod;
    RESET = 1'b0; WRITE = 1'b0; BUSYWAIT = 1'b0; IN = '0; INADDRESS = '0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0;

    //          rst  wr   busy wa    wd     a1    a2    e1     e2     ep
    tbl[0]  = '{1'b0,1'b1,1'b0,3'd3,8'h5A,3'd3,3'd3,8'h00,8'h00,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,3'd3,8'h5A,3'd3,3'd0,8'h5A,8'h00,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,3'd3,8'hEE,3'd3,3'd0,8'h5A,8'h00,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,3'd0,8'h00,3'd3,3'd0,8'h00,8'h00,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,3'd1,8'h03,3'd1,3'd2,8'h03,8'h00,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,3'd2,8'h02,3'd1,3'd2,8'h03,8'h02,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,3'd5,8'hC3,3'd5,3'd5,8'hC3,8'hC3,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b1,3'd0,8'h00,3'd5,3'd1,8'hC3,8'h03,1'b1};
    tbl[8]  = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd5,3'd5,8'hC3,8'hC3,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b1,3'd6,8'h11,3'd6,3'd7,8'h11,8'h00,1'b1};
    tbl[10] = '{1'b1,1'b1,1'b0,3'd6,8'h22,3'd6,3'd7,8'h22,8'h00,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b1,3'd6,8'h11,3'd6,3'd7,8'h11,8'h00,1'b1};
    tbl[12] = '{1'b1,1'b1,1'b0,3'd7,8'h22,3'd6,3'd7,8'h11,8'h22,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b1,3'd2,8'hFF,3'd2,3'd1,8'hFF,8'h03,1'b1};
    tbl[14] = '{1'b0,1'b0,1'b1,3'd0,8'h00,3'd2,3'd1,8'h00,8'h00,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd2,3'd1,8'h00,8'h00,1'b0};
    tbl[16] = '{1'b1,1'b1,1'b1,3'd0,8'h01,3'd0,3'd1,8'h01,8'h00,1'b1};
    tbl[17] = '{1'b1,1'b1,1'b1,3'd1,8'h02,3'd0,3'd1,8'h00,8'h02,1'b1};
    tbl[18] = '{1'b1,1'b0,1'b0,3'd0,8'h00,3'd0,3'd1,8'h00,8'h02,1'b0};
    tbl[19] = '{1'b1,1'b0,1'b0,3'd4,8'h77,3'd0,3'd1,8'h00,8'h02,1'b0};

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst_n, tbl[i].wr, tbl[i].busy, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2);
      check($sformatf("table[%0d]", i), tbl[i].e1, tbl[i].e2, tbl[i].ep);
    end

    // Multiply write-back: r1=3, r2=2, product goes to r4.
    drive(1'b1, 1'b1, 1'b0, 3'd1, 8'd3, 3'd1, 3'd2);
    drive(1'b1, 1'b1, 1'b0, 3'd2, 8'd2, 3'd1, 3'd2);
    check("mul_operands", 8'd3, 8'd2, 1'b0);
    prod = OUT1 * OUT2;
    drive(1'b1, 1'b1, 1'b0, 3'd4, prod, 3'd4, 3'd4);
    check("mul_result_r4", 8'd6, 8'd6, 1'b0);

    // Random traffic against the reference model, starting from reset.
    drive(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    model_edge(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check("rand_reset", 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < 400; c++) begin
      logic       r, w, b;
      logic [2:0] wa, a1, a2;
      logic [7:0] wd;
      r  = ($urandom_range(0, 49) != 0);
      w  = ($urandom_range(0, 99) < 60);
      b  = ($urandom_range(0, 99) < 40);
      wa = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      a1 = 3'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 3'($urandom_range(0, 7));
      drive(r, w, b, wa, wd, a1, a2);
      model_edge(r, w, b, wa, wd);
      check($sformatf("rand[%0d]", c), model_rd(a1), model_rd(a2), m_pv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_8x8.md
# reg_file_8x8

Eight-entry, 8-bit register file that supplies operands DATA1/DATA2 to the ALU (including the `multiply` unit) and accepts ALU results for write-back.
- Two combinational read ports, one synchronous write port.
- A one-entry pending-write buffer absorbs write-back requests that arrive while the memory stage holds BUSYWAIT, and commits them once the stall clears.
- Reads bypass the pending entry, so ALU operands are always the architecturally newest values.

## Interface
- NREGS, 8, number of registers; fixed at 8 so addresses stay 3 bits.
- WIDTH, 8, register and data width.
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  reset; synchronous, active-low.
- IN  input  8  write-back data (ALU RESULT or load data).
- INADDRESS  input  3  destination register.
- WRITE  input  1  write request, sampled at rising edge.
- BUSYWAIT  input  1  memory-stage stall; high blocks commits to the array.
- OUT1ADDRESS  input  3  read port 1 address.
- OUT2ADDRESS  input  3  read port 2 address.
- OUT1  output  8  read data 1; feeds ALU DATA1.
- OUT2  output  8  read data 2; feeds ALU DATA2.
- PENDING  output  1  pending-write buffer occupied.

## Operation
- **Reset.**
  - Reset is synchronous and active-low: at a rising edge with RESET=0, all 8 registers are cleared to 8'h00 and the pending buffer is cleared (PENDING=0).
  - Reset overrides any concurrent WRITE.
  - A pending write that has not committed when reset arrives is discarded.
- **Write, BUSYWAIT=0, buffer empty.** At the rising edge with WRITE=1, IN is stored into reg[INADDRESS].
- **Write, BUSYWAIT=1.** At the rising edge with WRITE=1, {INADDRESS, IN} is captured into the pending buffer and PENDING is set. The array is not modified.
- **Commit.** At the rising edge where PENDING=1 and BUSYWAIT=0, the buffered data is written to the array and PENDING clears.
- **Same-edge commit and new write.**
  - If WRITE=1 at that same edge, the new write proceeds directly to the array.
  - If both target the same address, the new write wins: the buffered value is dropped.
- **Second write while stalled.** With PENDING=1 and BUSYWAIT=1, a new WRITE=1 overwrites the buffer (last-write-wins). The controller is not expected to issue this; the behaviour is defined regardless.
- **Reads.**
  - OUTn = pending data when PENDING=1 and OUTnADDRESS matches the buffered address; otherwise OUTn = reg[OUTnADDRESS].
  - There is no bypass from the IN port itself. A value written at edge k is visible only after that edge.
- OUT1ADDRESS and OUT2ADDRESS may be equal; both ports then return the same value.
- WRITE=0 never changes any state.

## Timing
- **Read path:** combinational from address, array, or buffer change to OUT1/OUT2, with #2 model delay.
- **Write path:** array and buffer update #1 after the rising edge.
- **Reset values:** reg[0..7]=0, OUT1=OUT2=0 (after read delay), PENDING=0.
- **Write latency:**
  - 1 edge when not stalled.
  - With a stall, the value is visible on the read ports #2 after the capturing edge (via bypass) and commits to the array on the first edge with BUSYWAIT=0.
- **PENDING** is a registered output: it asserts #1 after the capturing edge and deasserts #1 after the commit edge.

## Structure
- **Shared package:** REG_ADDR_W=3, REG_DATA_W=8, REG_RESET_VAL=8'h00, read delay 2, write delay 1. The ALU and control unit reuse these constants.
- **Sub-module `reg_wb_buffer`:**
  - Holds valid, address and data.
  - Owns the capture, commit and drop rules.
  - Exposes a per-port match/data bypass.
- **Top level:** the array, write-select mux (direct vs. commit), and read muxes.

## Test plan
- **Reset clear.** Write 8'h5A to r3, then RESET=0 for one edge → OUT1 (addr 3)=8'h00, PENDING=0. Verify that RESET held high while WRITE=1 does not clear.
- **Basic write/read.** Write r1=8'd3 and r2=8'd2 in consecutive cycles, read OUT1=r1 and OUT2=r2 → 3 and 2. Feed these to the multiplier and check RESULT=6 written back to r4 reads 8'd6.
- **Stalled write.** BUSYWAIT=1, WRITE r5=8'hC3 → PENDING=1, OUT1 (addr 5)=8'hC3 via bypass. Array r5 stays old until BUSYWAIT falls; at the next edge PENDING=0 and r5=8'hC3.
- **Same-edge commit and write, same address.**
  - Pending r6=8'h11; at the edge where BUSYWAIT falls, WRITE r6=8'h22 → r6=8'h22.
  - Repeat with the new write to r7=8'h22 → r6=8'h11, r7=8'h22.
- **Reset mid-stall.** Pending r2=8'hFF with BUSYWAIT=1, then RESET=0 → PENDING=0, r2=8'h00; no commit after BUSYWAIT falls.
- **Overwrite while stalled.** Two WRITEs during BUSYWAIT=1 (r0=8'h01, then r1=8'h02) → after commit r1=8'h02 and r0 unchanged (8'h00).
